vga_capture: RTL and testbench

- Receive-side counterpart of the team's 640x480@60 VGA controller. Samples `hs`/`vs`/`r`/`g`/`b` exactly as the controller drives them, on the same 25 MHz pixel clock.
- Locks to the sync timing, recovers pixel coordinates, and issues one write per active pixel into a pixel RAM (row 0-479, col 0-639).
- Used for loopback self-test of the display path and for frame capture.

---
 rtl/vga_capture_if.sv | 15 +
 rtl/vga_capture.sv | 110 +++++++++++
 tb/tb_vga_capture.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// rtl/vga_capture_if.sv - video input and pixel RAM write port of vga_capture
interface vga_capture_if;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        wen;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [11:0] wr_data;

    modport master (output hs, vs, r, g, b, input wen, wr_row, wr_col, wr_data);
    modport slave  (input hs, vs, r, g, b, output wen, wr_row, wr_col, wr_data);
endinterface

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - locks to VGA sync timing and writes active pixels to a pixel RAM
module vga_capture #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic         vga_clk,
    input  logic         rst,
    vga_capture_if.slave vid,
    input  logic         cap_en,
    output logic         locked,
    output logic         frame_done,
    output logic         sync_err
);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_BEGIN  = 10'(H_START);
    localparam logic [9:0] H_END    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_BEGIN  = 10'(V_START);
    localparam logic [9:0] V_END    = 10'(V_START + V_ACTIVE);
    localparam logic [8:0] ROW_LAST = 9'(V_ACTIVE - 1);
    localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state, state_next;
    logic        hs_q, vs_q;
    logic [9:0]  hcnt, vcnt;
    logic        armed;
    logic        hs_fall, vs_fall;
    logic        line_err, frame_err, sync_bad;
    logic        in_window, active;
    logic [9:0]  col_off;
    logic [8:0]  row_off;

    assign hs_fall   = hs_q & ~vid.hs;
    assign vs_fall   = vs_q & ~vid.vs;
    assign line_err  = hs_fall && (hcnt != H_LAST);
    assign frame_err = vs_fall && (vcnt != V_LAST);
    assign sync_bad  = line_err || frame_err;
    assign in_window = (hcnt >= H_BEGIN) && (hcnt < H_END) &&
                       (vcnt >= V_BEGIN) && (vcnt < V_END);
    // Requiring LOCKED in both this and the next cycle kills the write on the error cycle.
    assign active    = (state == LOCKED) && (state_next == LOCKED) && armed && in_window;
    assign col_off   = hcnt - H_BEGIN;
    assign row_off   = 9'(vcnt - V_BEGIN);
    assign locked    = (state == LOCKED);

    always_ff @(posedge vga_clk) begin
        if (rst) state <= SEARCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH: if (vs_fall) state_next = CHECK;
            CHECK: begin
                if (sync_bad)     state_next = SEARCH;
                else if (vs_fall) state_next = LOCKED;
            end
            LOCKED: if (sync_bad) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            armed       <= 1'b0;
            vid.wen     <= 1'b0;
            vid.wr_row  <= '0;
            vid.wr_col  <= '0;
            vid.wr_data <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            hs_q <= vid.hs;
            vs_q <= vid.vs;

            if (hs_fall)              hcnt <= '0;
            else if (hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;

            if (vs_fall)                         vcnt <= '0;
            else if (hs_fall && vcnt != CNT_MAX) vcnt <= vcnt + 10'd1;

            // Arming is decided only at the frame-start vs_fall; cap_en is ignored elsewhere.
            if (state_next != LOCKED) armed <= 1'b0;
            else if (vs_fall)         armed <= cap_en;

            vid.wen <= active;
            if (active) begin
                vid.wr_col  <= col_off;
                vid.wr_row  <= row_off;
                vid.wr_data <= {vid.r, vid.g, vid.b};
            end

            frame_done <= vid.wen && (vid.wr_row == ROW_LAST) && (vid.wr_col == COL_LAST);

            if (state == LOCKED && sync_bad) sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - randomized loopback bench for vga_capture on a reduced raster
module tb_vga_capture;
    localparam int HT   = 40;
    localparam int VT   = 20;
    localparam int H_ST = 8;
    localparam int V_ST = 3;
    localparam int H_AC = 24;
    localparam int V_AC = 12;
    localparam int HSW  = 4;
    localparam int VSW  = 2;

    logic vga_clk;
    logic rst;
    logic cap_en;
    logic locked;
    logic frame_done;
    logic sync_err;

    vga_capture_if vid ();

    vga_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(H_ST), .V_START(V_ST),
        .H_ACTIVE(H_AC), .V_ACTIVE(V_AC)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .vid        (vid),
        .cap_en     (cap_en),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lock_count = 0;
    bit exp_sync_err = 1'b0;
    int prev_lines = VT;
    int exp_idx, n_wr, n_done;
    bit prev_last, any_locked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_f(input int row, input int col);
        logic [3:0] rr, cc;
        rr = row[3:0];
        cc = col[3:0];
        return {rr, cc, rr ^ cc};
    endfunction

    task automatic cyc(input bit h, input bit v, input bit ce, input logic [11:0] pix, input bit first);
        vid.hs = h;
        vid.vs = v;
        cap_en = ce;
        {vid.r, vid.g, vid.b} = pix;
        @(negedge vga_clk);
        if (vid.wen) begin
            check("wr_addr", {vid.wr_row, vid.wr_col}, {9'(exp_idx / H_AC), 10'(exp_idx % H_AC)});
            check("wr_data", vid.wr_data, pix_f(exp_idx / H_AC, exp_idx % H_AC));
            exp_idx++;
            n_wr++;
        end
        if (frame_done || prev_last) check("frame_done_timing", frame_done, prev_last);
        prev_last = vid.wen && vid.wr_row == 9'(V_AC - 1) && vid.wr_col == 10'(H_AC - 1);
        if (frame_done) n_done++;
        if (!first && locked) any_locked = 1'b1;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        vid.hs = 1'b1;
        vid.vs = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            if (i > 0) begin
                check("rst_wr", {vid.wen, vid.wr_row, vid.wr_col}, 0);
                check("rst_flags", {vid.wr_data, locked, frame_done, sync_err}, 0);
            end
            @(posedge vga_clk);
            #1;
        end
        rst = 1'b0;
        @(negedge vga_clk);
        check("post_rst", {vid.wen, locked, frame_done, sync_err}, 0);
        @(posedge vga_clk);
        #1;
        lock_count   = 0;
        exp_sync_err = 1'b0;
        prev_last    = 1'b0;
    endtask

    // One frame of n_lines lines; line bad_line lasts bad_len clocks; abort_line >= 0 stops mid-frame.
    task automatic send_frame(input int n_lines, input int bad_line, input int bad_len,
                              input bit cap, input int abort_line, input int abort_pos);
        int  exp_wr, rows, len;
        bit  armed, err_mid, exp_any;
        logic [11:0] pix;

        // Lock model: first vs_fall starts a trial, a clean trial frame locks, any error restarts.
        if (lock_count == 0) lock_count = 1;
        else if (prev_lines != VT) begin
            if (lock_count == 2) exp_sync_err = 1'b1;
            lock_count = 0;
        end else lock_count = 2;
        prev_lines = n_lines;
        armed   = (lock_count == 2) && cap;
        exp_any = (lock_count == 2);
        err_mid = (bad_line >= 0) && (bad_line < n_lines - 1) && (lock_count >= 1);
        exp_wr  = armed ? H_AC * V_AC : 0;
        if (armed && err_mid) begin
            rows = bad_line - V_ST + 1;
            if (rows < 0)    rows = 0;
            if (rows > V_AC) rows = V_AC;
            exp_wr = rows * H_AC;
        end
        if (err_mid) begin
            if (lock_count == 2) exp_sync_err = 1'b1;
            lock_count = 0;
        end

        n_wr = 0; n_done = 0; exp_idx = 0; any_locked = 1'b0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == bad_line) ? bad_len : HT;
            for (int p = 0; p < len; p++) begin
                if (l == abort_line && p == abort_pos) return;
                if (l >= V_ST && l < V_ST + V_AC && p > H_ST && p <= H_ST + H_AC)
                    pix = pix_f(l - V_ST, p - H_ST - 1);
                else
                    pix = 12'($urandom);
                cyc(!(p < HSW), !(l < VSW), (l == 0 && p == 0) ? cap : 1'($urandom_range(0, 1)),
                    pix, l == 0 && p == 0);
            end
        end
        check("writes", n_wr, exp_wr);
        check("frame_done_cnt", n_done, (exp_wr == H_AC * V_AC && exp_wr != 0) ? 1 : 0);
        check("locked_end", locked, lock_count == 2);
        check("locked_seen", any_locked, exp_any);
        check("sync_err", sync_err, exp_sync_err);
        if (exp_wr == H_AC * V_AC)
            check("wr_hold", {vid.wr_row, vid.wr_col}, {9'(V_AC - 1), 10'(H_AC - 1)});
    endtask

    function automatic int rand_line();
        return int'($urandom_range(V_ST + 1, V_ST + V_AC - 2));
    endfunction

    initial begin
        rst = 1'b1;
        cap_en = 1'b0;
        vid.hs = 1'b1; vid.vs = 1'b1;
        {vid.r, vid.g, vid.b} = 12'h000;
        prev_last = 1'b0;
        do_reset(3);

        repeat (3) send_frame(VT, -1, HT, 1'b1, -1, 0);

        send_frame(VT, -1, HT, 1'b1, V_ST + 2, 20);
        do_reset(3);
        repeat (3) send_frame(VT, -1, HT, 1'($urandom_range(0, 1)), -1, 0);

        do_reset(3);
        send_frame(VT - 1, -1, HT, 1'b1, -1, 0);
        repeat (3) send_frame(VT, -1, HT, 1'b1, -1, 0);

        send_frame(VT, rand_line(), HT - 1, 1'b1, -1, 0);
        repeat (3) send_frame(VT, -1, HT, 1'b1, -1, 0);

        send_frame(VT, -1, HT, 1'b0, -1, 0);
        send_frame(VT, -1, HT, 1'b1, -1, 0);

        send_frame(VT, rand_line(), 2000, 1'b1, -1, 0);
        repeat (3) send_frame(VT, -1, HT, 1'b1, -1, 0);

        repeat (5) begin
            if ($urandom_range(0, 3) == 0)
                send_frame(VT, rand_line(), ($urandom_range(0, 1) != 0) ? HT + 1 : HT - 1,
                           1'($urandom_range(0, 1)), -1, 0);
            else
                send_frame(VT, -1, HT, 1'($urandom_range(0, 1)), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
